// File: rtl/writeback_arb.sv
// Writeback arbiter: per-channel {rd, data} queues from the execute lanes, merged
// round-robin onto the single register-file write port through registered outputs.
module writeback_arb #(
  parameter int NCH   = 2,
  parameter int DEPTH = 2,
  parameter int W_RD  = 5,
  parameter int WORD  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       v_i,
  output logic [NCH-1:0]       stall_o,
  input  logic [NCH-1:0]       wb_i,
  input  logic [NCH*W_RD-1:0]  rd_num_i,
  input  logic [NCH*WORD-1:0]  rd_data_i,
  output logic                 wb_o,
  output logic [W_RD-1:0]      wbr_num_o,
  output logic [WORD-1:0]      wb_data_o,
  output logic [NCH-1:0]       gnt_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0]   cnt    [NCH];
  logic [PW-1:0]   rptr   [NCH];
  logic [PW-1:0]   wptr   [NCH];
  logic [W_RD-1:0] q_num  [NCH][DEPTH];
  logic [WORD-1:0] q_data [NCH][DEPTH];

  logic [RW-1:0]   rr;
  logic [RW-1:0]   win;
  logic            pop_any;
  logic [NCH-1:0]  push;
  logic [NCH-1:0]  pop;
  logic [NCH-1:0]  nonempty;
  int              idx;

  // Stall looks only at the registered count, so a full queue refuses a beat
  // even in a cycle where it is also being popped.
  always_comb begin
    stall_o  = '0;
    nonempty = '0;
    push     = '0;
    for (int c = 0; c < NCH; c++) begin
      stall_o[c]  = (cnt[c] == CW'(DEPTH));
      nonempty[c] = (cnt[c] != '0);
      push[c]     = v_i[c] & ~stall_o[c] & wb_i[c] & (rd_num_i[c*W_RD +: W_RD] != '0);
    end
  end

  always_comb begin
    pop_any = 1'b0;
    win     = '0;
    idx     = 0;
    pop     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr) + k) % NCH;
      if (!pop_any && nonempty[idx]) begin
        pop_any = 1'b1;
        win     = RW'(idx);
      end
    end
    if (pop_any) pop[win] = 1'b1;
  end

  assign busy_o = (|nonempty) | wb_o;

  // Queue storage carries no reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst && push[c]) begin
        q_num[c][wptr[c]]  <= rd_num_i[c*W_RD +: W_RD];
        q_data[c][wptr[c]] <= rd_data_i[c*WORD +: WORD];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        cnt[c]  <= '0;
        rptr[c] <= '0;
        wptr[c] <= '0;
      end
      rr        <= '0;
      wb_o      <= 1'b0;
      wbr_num_o <= '0;
      wb_data_o <= '0;
      gnt_o     <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wptr[c] <= wptr[c] + PW'(1);
        if (pop[c])  rptr[c] <= rptr[c] + PW'(1);
        if (push[c] && !pop[c])      cnt[c] <= cnt[c] + CW'(1);
        else if (pop[c] && !push[c]) cnt[c] <= cnt[c] - CW'(1);
      end
      if (pop_any) begin
        rr        <= (win == RW'(NCH - 1)) ? '0 : win + RW'(1);
        wb_o      <= 1'b1;
        wbr_num_o <= q_num[win][rptr[win]];
        wb_data_o <= q_data[win][rptr[win]];
        gnt_o     <= pop;
      end else begin
        wb_o      <= 1'b0;
        wbr_num_o <= '0;
        wb_data_o <= '0;
        gnt_o     <= '0;
      end
    end
  end

endmodule
